// File: rtl/pwm_meter_pkg.sv
// pwm_meter_pkg
// Shared types, widths and helper functions for the PWM duty meter.
//   state_t  : measurement FSM states
//   CNT_W    : width of the high-time / period counters (saturating)
//   DUTY_W   : width of the reported duty (sixteenths)
//   ROUND_C  : rounding offset applied before dividing by 16
package pwm_meter_pkg;

  localparam int CNT_W   = 10;
  localparam int DUTY_W  = 4;
  localparam int ROUND_C = 8;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [DUTY_W-1:0] DUTY_MAX = {DUTY_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } state_t;

  // Counter increment that sticks at the top value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Duty in sixteenths of the measured high time: (high + 8) >> 4,
  // clipped to the largest value the duty field can carry.
  function automatic logic [DUTY_W-1:0] duty_of(input logic [CNT_W-1:0] high);
    logic [CNT_W:0] sum;
    logic [CNT_W:0] shifted;
    sum     = {1'b0, high} + (CNT_W+1)'(ROUND_C);
    shifted = sum >> DUTY_W;
    if (shifted > (CNT_W+1)'(DUTY_MAX)) begin
      return DUTY_MAX;
    end
    return shifted[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync
// Brings the asynchronous PWM input into the clock domain and flags edges.
//   clk   : clock
//   rst_n : active-low reset (asynchronous assert, released synchronously upstream)
//   din   : raw asynchronous input
//   level : synchronized level (second synchronizer flop)
//   rise  : one-cycle pulse on a synchronized 0->1 transition
//   fall  : one-cycle pulse on a synchronized 1->0 transition
// An edge becomes visible to downstream logic on the third rising clock edge
// after din changes.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       meta_reg;
  logic       sync_reg;
  logic       prev_reg;
  logic [1:0] fill_reg;
  logic       primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
      fill_reg <= 2'd0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
      if (fill_reg != 2'd3) begin
        fill_reg <= fill_reg + 2'd1;
      end
    end
  end

  // The chain comes out of reset holding zeros; if the input is already high
  // that would look like a rising edge mid-phase. Edges are only trusted once
  // all three flops have been loaded from the real input.
  assign primed = (fill_reg == 2'd3);

  assign level = sync_reg;
  assign rise  = primed &  sync_reg & ~prev_reg;
  assign fall  = primed & ~sync_reg &  prev_reg;

endmodule

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter
// Measures the duty (in sixteenths) and period of a PWM input, and flags an
// input that has stopped toggling.
//   clk_50M     : clock
//   rst_n       : asynchronous active-low reset (release is synchronized)
//   pwm_in      : asynchronous PWM waveform
//   duty_out    : last measured duty, (high + 8) >> 4 saturated to 15
//   period_out  : last measured period in clock cycles
//   duty_valid  : one-cycle pulse when duty_out / period_out update
//   period_ok   : last period within NOM_PERIOD +/- PERIOD_TOL
//   stuck       : no input edge for TIMEOUT_CYC cycles
//   stuck_level : synchronized input level captured when stuck was raised
module pwm_duty_meter
  import pwm_meter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 512,
  parameter int NOM_PERIOD  = 256,
  parameter int PERIOD_TOL  = 8
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic [CNT_W-1:0]  period_out,
  output logic              duty_valid,
  output logic              period_ok,
  output logic              stuck,
  output logic              stuck_level
);

  localparam int                SINCE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SINCE_W-1:0] SINCE_LAST = SINCE_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  PER_MIN    = CNT_W'(NOM_PERIOD - PERIOD_TOL);
  localparam logic [CNT_W-1:0]  PER_MAX    = CNT_W'(NOM_PERIOD + PERIOD_TOL);

  logic [1:0]         rst_pipe_reg;
  logic               rst_int_n;
  logic               level;
  logic               rise;
  logic               fall;
  logic               any_edge;
  logic               timeout;
  logic               complete;
  logic               enter_stuck;

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   high_cnt_reg;
  logic [CNT_W-1:0]   high_cnt_next;
  logic [CNT_W-1:0]   period_cnt_reg;
  logic [CNT_W-1:0]   period_cnt_next;
  logic [SINCE_W-1:0] since_reg;
  logic [SINCE_W-1:0] since_next;

  logic [DUTY_W-1:0]  duty_reg;
  logic [CNT_W-1:0]   period_reg;
  logic               duty_valid_reg;
  logic               period_ok_reg;
  logic               stuck_level_reg;

  // Reset asserts immediately but is released two clock edges later, so every
  // flop below leaves reset on the same cycle.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe_reg <= 2'b00;
    end else begin
      rst_pipe_reg <= {rst_pipe_reg[0], 1'b1};
    end
  end
  assign rst_int_n = rst_pipe_reg[1];

  pwm_edge_sync u_edge_sync (
    .clk   (clk_50M),
    .rst_n (rst_int_n),
    .din   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign any_edge = rise | fall;
  // since_reg counts cycles after the last edge; the timeout fires on the
  // TIMEOUT_CYC-th edge-free cycle following it.
  assign timeout  = !any_edge && (since_reg == SINCE_LAST);

  // FSM: state register
  always_ff @(posedge clk_50M or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (rise)         state_next = HIGH;
        else if (timeout) state_next = STUCK;
      end
      HIGH: begin
        if (fall)         state_next = LOW;
        else if (timeout) state_next = STUCK;
      end
      LOW: begin
        if (rise)         state_next = HIGH;
        else if (timeout) state_next = STUCK;
      end
      STUCK: begin
        if (rise)         state_next = HIGH;
        else if (fall)    state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs and counter control
  always_comb begin
    complete        = 1'b0;
    high_cnt_next   = high_cnt_reg;
    period_cnt_next = period_cnt_reg;
    case (state_reg)
      IDLE, STUCK: begin
        // A rising edge starts a fresh period; the edge cycle itself counts.
        if (rise) begin
          high_cnt_next   = CNT_W'(1);
          period_cnt_next = CNT_W'(1);
        end
      end
      HIGH: begin
        // The falling-edge cycle already belongs to the low phase.
        period_cnt_next = sat_inc(period_cnt_reg);
        if (!fall) begin
          high_cnt_next = sat_inc(high_cnt_reg);
        end
      end
      LOW: begin
        if (rise) begin
          complete        = 1'b1;
          high_cnt_next   = CNT_W'(1);
          period_cnt_next = CNT_W'(1);
        end else begin
          period_cnt_next = sat_inc(period_cnt_reg);
        end
      end
      default: ;
    endcase
    enter_stuck = (state_next == STUCK) && (state_reg != STUCK);
    stuck       = (state_reg == STUCK);
  end

  always_comb begin
    if (any_edge) begin
      since_next = '0;
    end else if (since_reg == SINCE_LAST) begin
      since_next = since_reg;
    end else begin
      since_next = since_reg + SINCE_W'(1);
    end
  end

  always_ff @(posedge clk_50M or negedge rst_int_n) begin
    if (!rst_int_n) begin
      high_cnt_reg    <= '0;
      period_cnt_reg  <= '0;
      since_reg       <= '0;
      duty_reg        <= '0;
      period_reg      <= '0;
      duty_valid_reg  <= 1'b0;
      period_ok_reg   <= 1'b0;
      stuck_level_reg <= 1'b0;
    end else begin
      high_cnt_reg   <= high_cnt_next;
      period_cnt_reg <= period_cnt_next;
      since_reg      <= since_next;
      duty_valid_reg <= complete;
      if (complete) begin
        duty_reg      <= duty_of(high_cnt_reg);
        period_reg    <= period_cnt_reg;
        period_ok_reg <= (period_cnt_reg >= PER_MIN) && (period_cnt_reg <= PER_MAX);
      end
      if (enter_stuck) begin
        stuck_level_reg <= level;
      end
    end
  end

  assign duty_out    = duty_reg;
  assign period_out  = period_reg;
  assign duty_valid  = duty_valid_reg;
  assign period_ok   = period_ok_reg;
  assign stuck_level = stuck_level_reg;

endmodule
